// File: rtl/serial_magnitude_comparator_pkg.sv
// Shared types and flag decoding for the serial magnitude comparator.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
package comparator_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      COMPARE = 1'b1
   } cmp_state_t;

   typedef enum logic [1:0] {
      CMP_NONE = 2'd0,
      CMP_EQ   = 2'd1,
      CMP_GT   = 2'd2,
      CMP_LT   = 2'd3
   } cmp_result_t;

   // Flag bits are ordered {equal, greater, less}; CMP_NONE yields all zero.
   function automatic logic [2:0] decode_flags(input cmp_result_t res);
      logic [2:0] flags;
      flags = 3'b000;
      case (res)
         CMP_EQ:  flags = 3'b100;
         CMP_GT:  flags = 3'b010;
         CMP_LT:  flags = 3'b001;
         default: flags = 3'b000;
      endcase
      return flags;
   endfunction

endpackage

// File: rtl/serial_magnitude_comparator_slice.sv
// Single-bit magnitude compare with optional inversion for a two's-complement sign bit.
// Latency: combinational.
// Backpressure: not applicable.
module bit_compare_slice (
   input  logic a_bit,
   input  logic b_bit,
   input  logic invert,
   output logic eq,
   output logic gt,
   output logic lt
);

   logic diff;

   // On the sign bit a set bit means "more negative", so the decision swaps.
   always_comb begin
      diff = a_bit ^ b_bit;
      eq   = ~diff;
      gt   = diff & (invert ? b_bit : a_bit);
      lt   = diff & (invert ? a_bit : b_bit);
   end

endmodule

// File: rtl/serial_magnitude_comparator.sv
// MSB-first serial compare of two WIDTH-bit operands, stopping at the first differing bit.
// Latency: 1..WIDTH cycles from accepted start to the done pulse (WIDTH-i for top differing bit i).
// Backpressure: start is only accepted while busy=0; requests during a compare are dropped.
module serial_magnitude_comparator
   import comparator_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter bit SIGNED = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             result_valid,
   output logic             a_equals_b,
   output logic             a_greater_b,
   output logic             a_less_b
);

   localparam int IDX_W = $clog2(WIDTH);
   localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

   cmp_state_t       state;
   logic [IDX_W-1:0] idx;
   logic [WIDTH-1:0] a_sh;
   logic [WIDTH-1:0] b_sh;

   logic        slice_invert;
   logic        slice_eq;
   logic        slice_gt;
   logic        slice_lt;
   cmp_result_t decision;

   // Only the first examined bit is the sign bit; later bits compare as magnitude.
   always_comb begin
      slice_invert = SIGNED && (idx == IDX_MSB);
   end

   bit_compare_slice u_msb_slice (
      .a_bit  (a_sh[WIDTH-1]),
      .b_bit  (b_sh[WIDTH-1]),
      .invert (slice_invert),
      .eq     (slice_eq),
      .gt     (slice_gt),
      .lt     (slice_lt)
   );

   // A decision exists on the first differing bit, or once the last bit matched.
   always_comb begin
      decision = CMP_NONE;
      if (slice_gt) begin
         decision = CMP_GT;
      end else if (slice_lt) begin
         decision = CMP_LT;
      end else if (slice_eq && (idx == '0)) begin
         decision = CMP_EQ;
      end
   end

   // Control FSM, operand shifters and registered result flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         idx          <= '0;
         a_sh         <= '0;
         b_sh         <= '0;
         busy         <= 1'b0;
         done         <= 1'b0;
         result_valid <= 1'b0;
         a_equals_b   <= 1'b0;
         a_greater_b  <= 1'b0;
         a_less_b     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_sh         <= a;
                  b_sh         <= b;
                  idx          <= IDX_MSB;
                  busy         <= 1'b1;
                  result_valid <= 1'b0;
                  a_equals_b   <= 1'b0;
                  a_greater_b  <= 1'b0;
                  a_less_b     <= 1'b0;
                  state        <= COMPARE;
               end
            end
            COMPARE: begin
               if (decision != CMP_NONE) begin
                  {a_equals_b, a_greater_b, a_less_b} <= decode_flags(decision);
                  done         <= 1'b1;
                  result_valid <= 1'b1;
                  busy         <= 1'b0;
                  state        <= IDLE;
               end else begin
                  a_sh <= {a_sh[WIDTH-2:0], 1'b0};
                  b_sh <= {b_sh[WIDTH-2:0], 1'b0};
                  idx  <= idx - 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed-vector bench driving an unsigned and a signed comparator in lockstep.
// Latency: checks done timing in edges after the accepted start.
// Backpressure: exercises start-while-busy and start-in-done-cycle.
module tb_serial_magnitude_comparator;

   localparam int WIDTH = 8;

   logic             clk;
   logic             rst;
   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;

   logic busy_u, done_u, rv_u, eq_u, gt_u, lt_u;
   logic busy_s, done_s, rv_s, eq_s, gt_s, lt_s;

   int tests_run;
   int tests_failed;
   int n;

   serial_magnitude_comparator #(.WIDTH(WIDTH), .SIGNED(1'b0)) u_dut_unsigned (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a            (a),
      .b            (b),
      .busy         (busy_u),
      .done         (done_u),
      .result_valid (rv_u),
      .a_equals_b   (eq_u),
      .a_greater_b  (gt_u),
      .a_less_b     (lt_u)
   );

   serial_magnitude_comparator #(.WIDTH(WIDTH), .SIGNED(1'b1)) u_dut_signed (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .a            (a),
      .b            (b),
      .busy         (busy_s),
      .done         (done_s),
      .result_valid (rv_s),
      .a_equals_b   (eq_s),
      .a_greater_b  (gt_s),
      .a_less_b     (lt_s)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Present operands with start=1 so they are taken at the next edge (E0);
   // returns at the negedge after E0 with start released.
   task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv);
      start = 1'b1;
      a     = av;
      b     = bv;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Count edges after E0 until the unsigned done is seen, bounded.
   task automatic wait_done(inout int cnt);
      while (!done_u && cnt < 3 * WIDTH) begin
         @(negedge clk);
         cnt++;
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      rst   = 1'b1;
      start = 1'b0;
      a     = '0;
      b     = '0;
      @(negedge clk);
      @(negedge clk);

      // Reset state
      check("rst_u_out", {busy_u, done_u, rv_u, eq_u, gt_u, lt_u}, 6'b0);
      check("rst_s_out", {busy_s, done_s, rv_s, eq_s, gt_s, lt_s}, 6'b0);
      // Reset wins over start
      start = 1'b1;
      @(negedge clk);
      check("rst_over_start", {busy_u, busy_s}, 2'b00);
      start = 1'b0;
      rst   = 1'b0;
      @(negedge clk);

      // Equal operands: full WIDTH cycles
      issue(8'hA5, 8'hA5);
      check("eq_busy", {busy_u, busy_s, rv_u, done_u}, 4'b1100);
      n = 0;
      wait_done(n);
      check("eq_lat", n, 8);
      check("eq_flags_u", {eq_u, gt_u, lt_u}, 3'b100);
      check("eq_flags_s", {eq_s, gt_s, lt_s}, 3'b100);
      check("eq_done_rv", {done_s, rv_u, rv_s, busy_u}, 4'b1110);
      @(negedge clk);
      @(negedge clk);
      check("eq_hold", {done_u, rv_u, eq_u}, 3'b011);

      // MSB decides; sign inverts it
      issue(8'h80, 8'h7F);
      n = 0;
      wait_done(n);
      check("msb_lat", n, 1);
      check("msb_flags_u", {eq_u, gt_u, lt_u}, 3'b010);
      check("msb_flags_s", {eq_s, gt_s, lt_s}, 3'b001);
      check("msb_done_s", done_s, 1'b1);
      @(negedge clk);

      // LSB decides
      issue(8'h12, 8'h13);
      n = 0;
      wait_done(n);
      check("lsb_lat", n, 8);
      check("lsb_flags_u", {eq_u, gt_u, lt_u}, 3'b001);
      check("lsb_flags_s", {eq_s, gt_s, lt_s}, 3'b001);
      @(negedge clk);

      // Negative operands, bit 3 differs
      issue(8'hF0, 8'hF8);
      n = 0;
      wait_done(n);
      check("neg_lat", n, 5);
      check("neg_flags_s", {eq_s, gt_s, lt_s}, 3'b001);
      check("neg_flags_u", {eq_u, gt_u, lt_u}, 3'b001);
      @(negedge clk);

      // Start while busy is ignored
      issue(8'h00, 8'h01);
      @(negedge clk);                 // after E1
      start = 1'b1;
      a     = 8'hFF;
      b     = 8'h00;
      @(negedge clk);                 // after E2: ignored request
      start = 1'b0;
      n = 2;
      wait_done(n);
      check("busy_ign_lat", n, 8);
      check("busy_ign_u", {eq_u, gt_u, lt_u}, 3'b001);
      check("busy_ign_s", {eq_s, gt_s, lt_s}, 3'b001);

      // Start in the done cycle is accepted and clears results at that edge
      issue(8'h03, 8'h03);
      check("done_start_clr", {done_u, rv_u, eq_u, gt_u, lt_u, busy_u}, 6'b000001);
      check("done_start_clr_s", {done_s, rv_s, eq_s, gt_s, lt_s, busy_s}, 6'b000001);
      n = 0;
      wait_done(n);
      check("done_start_lat", n, 8);
      check("done_start_eq", {eq_u, gt_u, lt_u}, 3'b100);
      @(negedge clk);

      // Reset mid-compare aborts with no done
      issue(8'h55, 8'h55);            // E0
      @(negedge clk);                 // after E1
      @(negedge clk);                 // after E2
      rst = 1'b1;
      @(negedge clk);                 // after E3
      rst = 1'b0;
      check("abort_u", {busy_u, done_u, rv_u, eq_u, gt_u, lt_u}, 6'b0);
      check("abort_s", {busy_s, done_s, rv_s, eq_s, gt_s, lt_s}, 6'b0);
      n = 0;
      repeat (8) begin
         @(negedge clk);
         if (done_u) n++;
      end
      check("abort_no_done", n, 0);

      // Normal compare after reset, bit 1 differs
      issue(8'h01, 8'h02);
      n = 0;
      wait_done(n);
      check("post_rst_lat", n, 7);
      check("post_rst_u", {eq_u, gt_u, lt_u}, 3'b001);
      check("post_rst_s", {eq_s, gt_s, lt_s}, 3'b001);
      @(negedge clk);

      // Signed positive vs negative
      issue(8'h01, 8'hFF);
      n = 0;
      wait_done(n);
      check("sgn_mix_lat", n, 1);
      check("sgn_mix_u", {eq_u, gt_u, lt_u}, 3'b001);
      check("sgn_mix_s", {eq_s, gt_s, lt_s}, 3'b010);
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
